// File: rtl/seq_detector_param.sv
// seq_detector_param
// Parametrised Moore serial-pattern detector. It has a configurable pattern
// length and value, an overlapping or non-overlapping match mode, a
// sample-enable qualifier and a saturating match counter.
//
// Parameters:
//   SEQ_LEN      pattern length, 2..16
//   SEQ_PATTERN  pattern value; bit SEQ_LEN-1 is the first bit on the wire
//   OVERLAP      1 = overlapping matches, 0 = restart from empty after a match
//   CNT_W        match counter width, 1..32
//
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous, active-high, clears all state
//   enable       data_in is sampled only on edges where enable=1
//   clear        synchronous clear of match depth, detected and match_count
//   data_in      serial data bit
//   detected     registered match flag (depth == SEQ_LEN)
//   match_count  saturating count of completed matches
//   progress     current match depth, 0..SEQ_LEN
//
// Optional feature (define SEQ_RUNTIME_LOAD_EN):
//   pattern_in   new pattern value
//   pattern_load loads pattern_in into the pattern register and restarts the
//                match; match_count is kept
//
// Depth states:
//   depth        | meaning
//   0            | empty, no prefix of the pattern matched
//   1..SEQ_LEN-1 | longest suffix of the sampled bits equal to a pattern prefix
//   SEQ_LEN      | MATCH, detected=1
module seq_detector_param #(
    parameter int                 SEQ_LEN     = 4,
    parameter logic [SEQ_LEN-1:0] SEQ_PATTERN = 4'b1010,
    parameter bit                 OVERLAP     = 1'b1,
    parameter int                 CNT_W       = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         clear,
    input  logic                         data_in,
`ifdef SEQ_RUNTIME_LOAD_EN
    input  logic [SEQ_LEN-1:0]           pattern_in,
    input  logic                         pattern_load,
`endif
    output logic                         detected,
    output logic [CNT_W-1:0]             match_count,
    output logic [$clog2(SEQ_LEN+1)-1:0] progress
);

    localparam int              DW      = $clog2(SEQ_LEN + 1);
    localparam logic [DW-1:0]   D_MATCH = DW'(SEQ_LEN);

    if (SEQ_LEN < 2 || SEQ_LEN > 16) begin : g_bad_seq_len
        $error("seq_detector_param: SEQ_LEN must be in 2..16");
    end
    if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
        $error("seq_detector_param: CNT_W must be in 1..32");
    end

    logic [DW-1:0]      depth_q;
    logic [DW-1:0]      depth_nxt;
    logic [SEQ_LEN-2:0] hist_q;
    logic [SEQ_LEN-1:0] window;
    logic [SEQ_LEN-1:0] mask;
    logic [SEQ_LEN-1:0] pat;
    int                 max_k;

`ifdef SEQ_RUNTIME_LOAD_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat <= SEQ_PATTERN;
        end else if (!clear && pattern_load) begin
            pat <= pattern_in;
        end
    end
`else
    assign pat = SEQ_PATTERN;
`endif

    // Run-time fall-back: the next depth is the longest k such that the
    // last k-1 sampled bits followed by data_in equal the k-bit pattern
    // prefix. k is capped at depth+1 so only bits inside the current match
    // are ever looked at; a non-overlapping MATCH restarts from empty, so
    // only k=1 is allowed there.
    always_comb begin
        window    = {hist_q, data_in};
        mask      = '0;
        depth_nxt = '0;
        if (depth_q == D_MATCH) begin
            max_k = OVERLAP ? SEQ_LEN : 1;
        end else begin
            max_k = int'(depth_q) + 1;
        end
        for (int k = 1; k <= SEQ_LEN; k++) begin
            mask = {SEQ_LEN{1'b1}} >> (SEQ_LEN - k);
            if (k <= max_k && (window & mask) == ((pat >> (SEQ_LEN - k)) & mask)) begin
                depth_nxt = DW'(k);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            depth_q     <= '0;
            hist_q      <= '0;
            detected    <= 1'b0;
            match_count <= '0;
        end else if (clear) begin
            depth_q     <= '0;
            hist_q      <= '0;
            detected    <= 1'b0;
            match_count <= '0;
`ifdef SEQ_RUNTIME_LOAD_EN
        end else if (pattern_load) begin
            depth_q  <= '0;
            hist_q   <= '0;
            detected <= 1'b0;
`endif
        end else if (enable) begin
            hist_q   <= window[SEQ_LEN-2:0];
            depth_q  <= depth_nxt;
            detected <= (depth_nxt == D_MATCH);
            if (depth_nxt == D_MATCH && match_count != {CNT_W{1'b1}}) begin
                match_count <= match_count + CNT_W'(1);
            end
        end
    end

    assign progress = depth_q;

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised Moore serial-pattern detector, the next-generation successor to the fixed 4-bit lab detector. It has a configurable pattern length and value, overlapping or non-overlapping match mode, a sample-enable qualifier, and a saturating match counter. It sits behind a serial bit source (switch or debounced input sampled on clk) and drives an LED or downstream logic.

Parameters:
SEQ_LEN, 4, pattern length in bits; legal range 2..16; elaboration error outside range.
SEQ_PATTERN, 4'b1010, pattern value. Width SEQ_LEN. Bit SEQ_LEN-1 is the first bit expected on the wire.
OVERLAP, 1, 1 = overlapping matches allowed; 0 = the detector restarts from empty after each match.
CNT_W, 8, match counter width; legal range 1..32.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-high; clears all state.
enable  input  1  data_in is sampled only on edges where enable=1.
clear  input  1  synchronous clear of match state and counter.
data_in  input  1  serial data bit.
detected  output  1  Moore match flag, registered.
match_count  output  CNT_W  saturating count of completed matches.
progress  output  $clog2(SEQ_LEN+1)  current match depth, 0..SEQ_LEN, for debug.

Behaviour:
- State: match depth d, 0..SEQ_LEN. d is the length of the longest suffix of the bits sampled since the last restart that equals a prefix of SEQ_PATTERN (MSB-first). d=SEQ_LEN is the MATCH state.
- Next depth on a sampled bit b, from depth d:
  - d<SEQ_LEN: if b equals pattern bit [SEQ_LEN-1-d], go to d+1. Otherwise fall back to the longest k≤d such that (the last k-1 matched bits followed by b) equals the pattern prefix of length k; 0 if none.
  - d=SEQ_LEN with OVERLAP=1: same fall-back rule applied over the full matched pattern plus b. This can re-enter MATCH directly, e.g. pattern 1111.
  - d=SEQ_LEN with OVERLAP=0: treat as d=0, then apply the rule to b.
- The implementation may use a precomputed failure table (generate-time function) or a SEQ_LEN-bit history compare. Only the observable behaviour is fixed.
- detected = (d==SEQ_LEN), taken directly from the state register. It rises in the cycle after the edge that sampled the final pattern bit.
- enable=0: d, detected and match_count hold. detected stays high while the block holds in MATCH.
- match_count increments by 1 on every sampled edge whose next depth is SEQ_LEN. It saturates at 2^CNT_W-1 and never wraps.
- Priority, highest first: reset, clear, enable.
  - clear=1: d←0, detected←0, match_count←0. data_in is ignored that cycle.
- Reset values: d=0, detected=0, match_count=0, progress=0.
- Reset mid-sequence: the partial match is discarded. The first post-reset bit is evaluated from d=0.
- progress = d.

Optional Feature:
SEQ_RUNTIME_LOAD_EN. When defined, the block adds input pattern_in [SEQ_LEN-1:0] and input pattern_load.
- pattern_load=1 (priority below clear, above enable) copies pattern_in into an internal pattern register and sets d←0, detected←0. match_count is unchanged.
- The pattern register resets to SEQ_PATTERN.
- All matching uses the pattern register, so fall-back must be computed at run time.
When not defined, the ports are absent and the pattern is the constant SEQ_PATTERN.

Test Plan:
1. Defaults (1010, OVERLAP=1), enable=1, stream 1,0,1,0,1,0 → detected high for one cycle after the 4th bit and one cycle after the 6th bit; match_count=2.
2. OVERLAP=0, same stream, then 1,0 → detected after bits 4 and 8 only; match_count=2; progress=2 after bit 6.
3. SEQ_PATTERN=4'b1101, stream 1,1,1,0,1 → progress 1,2,2,3,4; detected after the 5th bit; match_count=1.
4. Defaults: after bits 1,0,1,0 (detected=1), hold enable=0 for 3 cycles → detected stays 1 and match_count stays 1. Then enable=1, bit 0 → detected=0, progress=0.
5. CNT_W=2, OVERLAP=1, stream 1,0 repeated 12 times → match_count reaches 3 and stays 3. A clear pulse then gives match_count=0, detected=0.
6. Assert reset asynchronously mid-clock after bits 1,0,1 → all outputs 0 immediately. Post-reset stream 0,1,0 must not detect; a following 1,0 → detected after the 5th post-reset bit. With SEQ_RUNTIME_LOAD_EN: load 4'b0011, then stream 0,0,1,1 → detected.
